spike_detector: RTL and testbench

SPIKE_DETECTOR -- requirements
Module: spike_detector

---
 rtl/spike_pkg.sv | 17 +
 rtl/sync_fifo_fwft.sv | 54 +++++
 rtl/spike_detector.sv | 128 ++++++++++++
 tb/tb_spike_detector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared widths and event record layout for the spike detector.
// evt_t matches the upstream word layout {channel, timestamp, sample}.
package spike_pkg;

  localparam int SAMPLE_W_DEF  = 12;
  localparam int TS_W_DEF      = 16;
  localparam int CH_W_DEF      = 4;
  localparam int REFR_W_DEF    = 8;
  localparam int EVT_DEPTH_DEF = 8;

  typedef struct packed {
    logic [CH_W_DEF-1:0]     ch;
    logic [TS_W_DEF-1:0]     ts;
    logic [SAMPLE_W_DEF-1:0] sample;
  } evt_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The pointers carry one wrap bit
// beyond the address so that full and empty can be told apart.
module sync_fifo_fwft #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DW-1:0]            o_data,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_valid = !w_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/spike_detector.sv
// Per-channel threshold spike detector with refractory counters and an event FIFO.
// Stage 1 registers the word plus its channel state; the following edge commits it.
module spike_detector
  import spike_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int TS_W      = TS_W_DEF,
  parameter int CH_W      = CH_W_DEF,
  parameter int REFR_W    = REFR_W_DEF,
  parameter int EVT_DEPTH = EVT_DEPTH_DEF
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          in_valid,
  input  logic [CH_W+TS_W+SAMPLE_W-1:0] in_data,
  input  logic                          det_en,
  input  logic                          cfg_wr,
  input  logic [CH_W-1:0]               cfg_ch,
  input  logic [SAMPLE_W-1:0]           cfg_thresh,
  input  logic [REFR_W-1:0]             cfg_refract,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [CH_W+TS_W+SAMPLE_W-1:0] evt_data,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(EVT_DEPTH):0]    evt_level
);

  localparam int NCH = 1 << CH_W;
  localparam int DW  = CH_W + TS_W + SAMPLE_W;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [TS_W-1:0]     ts;
    logic [SAMPLE_W-1:0] sample;
  } word_t;

  logic [SAMPLE_W-1:0] r_thresh [NCH];
  logic [REFR_W-1:0]   r_refr   [NCH];

  logic                r_s1_vld;
  word_t               r_s1_word;
  logic [SAMPLE_W-1:0] r_s1_thr;
  logic [REFR_W-1:0]   r_s1_cnt;
  logic [7:0]          r_drop;

  word_t               w_in;
  logic                w_take;
  logic                w_spike;
  logic [REFR_W-1:0]   w_cnt_nxt;
  logic                w_fwd;
  logic                w_full;
  logic                w_drop;

  assign w_in   = word_t'(in_data);
  // Disabled words never enter the pipeline, so their channel state is untouched.
  assign w_take = in_valid && det_en;
  assign w_fwd  = r_s1_vld && (r_s1_word.ch == w_in.ch);

  always_comb begin
    w_spike   = r_s1_vld && (r_s1_word.sample >= r_s1_thr) && (r_s1_cnt == '0);
    w_cnt_nxt = r_s1_cnt;
    if (w_spike)
      w_cnt_nxt = cfg_refract;
    else if (r_s1_cnt != '0)
      w_cnt_nxt = r_s1_cnt - REFR_W'(1);
  end

  // Stage 1: capture word; counter is forwarded from the word being committed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
      r_s1_thr  <= '1;
      r_s1_cnt  <= '0;
    end else begin
      r_s1_vld <= w_take;
      if (w_take) begin
        r_s1_word <= w_in;
        r_s1_thr  <= r_thresh[w_in.ch];
        r_s1_cnt  <= w_fwd ? w_cnt_nxt : r_refr[w_in.ch];
      end
    end
  end

  // Channel state: config writes land after the same-cycle word has read the old value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_thresh[c] <= '1;
        r_refr[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_wr && (cfg_ch == CH_W'(c)))
          r_thresh[c] <= cfg_thresh;
        if (r_s1_vld && (r_s1_word.ch == CH_W'(c)))
          r_refr[c] <= w_cnt_nxt;
      end
    end
  end

  sync_fifo_fwft #(
    .DW    (DW),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_push  (w_spike),
    .i_data  (r_s1_word),
    .o_valid (evt_valid),
    .i_ready (evt_ready),
    .o_data  (evt_data),
    .o_full  (w_full),
    .o_level (evt_level)
  );

  assign w_drop = w_spike && w_full && !(evt_valid && evt_ready);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_drop <= '0;
    else if (w_drop && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_spike_detector.sv
// Self-checking bench: vector table plus hand sequences, with a scoreboard
// queue of expected events filled at stimulus time and drained on transfers.
module tb_spike_detector;
  import spike_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        det_en;
  logic        cfg_wr;
  logic [3:0]  cfg_ch;
  logic [11:0] cfg_thresh;
  logic [7:0]  cfg_refract;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_data;
  logic [7:0]  drop_cnt;
  logic [3:0]  evt_level;

  spike_detector dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .det_en      (det_en),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_thresh  (cfg_thresh),
    .cfg_refract (cfg_refract),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .drop_cnt    (drop_cnt),
    .evt_level   (evt_level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] ts;
    logic [11:0] s;
    logic        det;
    logic        exp_evt;
  } vec_t;

  vec_t        tbl [10];
  evt_t        q [$];
  evt_t        exp_e;
  logic [11:0] m_thr [16];
  logic [7:0]  m_cnt [16];
  int          m_drop;
  bit          m_pop_at_push;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_thr[i] = 12'hFFF;
      m_cnt[i] = 8'd0;
    end
    q.delete();
    m_drop = 0;
    m_pop_at_push = 1'b0;
  endtask

  // One clock; the scoreboard pops at the negedge before a transfer edge.
  task automatic tick();
    @(negedge sys_clk);
    if (sys_rst_n && evt_valid && evt_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_evt: got %0h expected none", evt_data);
      end else begin
        exp_e = q.pop_front();
        chk("evt_data", evt_data, exp_e);
      end
    end
    @(posedge sys_clk);
    if (cfg_wr) m_thr[cfg_ch] = cfg_thresh;
    #1;
    in_valid = 1'b0;
    cfg_wr   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input logic [3:0] ch, input logic [11:0] th);
    cfg_wr     = 1'b1;
    cfg_ch     = ch;
    cfg_thresh = th;
  endtask

  // Drives a word for the next edge and predicts its outcome in order.
  task automatic word(input logic [3:0] ch, input logic [15:0] ts, input logic [11:0] s);
    in_valid = 1'b1;
    in_data  = {ch, ts, s};
    if (det_en) begin
      if (s >= m_thr[ch] && m_cnt[ch] == 8'd0) begin
        m_cnt[ch] = cfg_refract;
        if (q.size() < 8 || m_pop_at_push) q.push_back(evt_t'({ch, ts, s}));
        else if (m_drop < 255) m_drop++;
      end else if (m_cnt[ch] != 8'd0) begin
        m_cnt[ch] = m_cnt[ch] - 8'd1;
      end
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    ticks(2);
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sys_rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; det_en = 1'b1;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_thresh = '0; cfg_refract = 8'd2;
    evt_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_evt_level", {28'd0, evt_level}, 32'd0);
    chk("rst_drop_cnt",  {24'd0, drop_cnt},  32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    tick();

    tbl[0] = '{4'd3, 16'h0010, 12'h900, 1'b1, 1'b1};
    tbl[1] = '{4'd3, 16'h0011, 12'h900, 1'b1, 1'b0};
    tbl[2] = '{4'd3, 16'h0012, 12'h900, 1'b1, 1'b0};
    tbl[3] = '{4'd3, 16'h0013, 12'h900, 1'b1, 1'b1};
    tbl[4] = '{4'd3, 16'h0014, 12'h7FF, 1'b1, 1'b0};
    tbl[5] = '{4'd3, 16'h0015, 12'h900, 1'b0, 1'b0};
    tbl[6] = '{4'd3, 16'h0016, 12'h100, 1'b1, 1'b0};
    tbl[7] = '{4'd3, 16'h0017, 12'h800, 1'b1, 1'b1};
    tbl[8] = '{4'd7, 16'h0018, 12'hFFE, 1'b1, 1'b0};
    tbl[9] = '{4'd5, 16'h0019, 12'h200, 1'b1, 1'b0};

    set_cfg(4'd3, 12'h800); tick();
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      det_en = tbl[i].det;
      word(tbl[i].ch, tbl[i].ts, tbl[i].s);
      tick();
      det_en = 1'b1;
      chk($sformatf("row%0d_early", i), {31'd0, evt_valid}, 32'd0);
      tick();
      chk($sformatf("row%0d_valid", i), {31'd0, evt_valid}, {31'd0, tbl[i].exp_evt});
    end
    ticks(3);

    // Back-to-back words on one channel: events on 1st and 4th only.
    set_cfg(4'd4, 12'h800); tick();
    for (int i = 0; i < 4; i++) begin
      word(4'd4, 16'h0020 + 16'(i), 12'h900);
      tick();
    end
    ticks(4);
    chk("b2b_drained", 32'(q.size()), 32'd0);

    // Config/word in the same cycle uses the old threshold.
    set_cfg(4'd5, 12'h100);
    word(4'd5, 16'h0030, 12'h200); tick();
    word(4'd5, 16'h0031, 12'h200); tick();
    chk("cfg_hazard_old", {31'd0, evt_valid}, 32'd0);
    tick();
    chk("cfg_hazard_new", {31'd0, evt_valid}, 32'd1);
    ticks(3);

    // Overflow: 10 spikes into an 8-deep FIFO with no pops.
    evt_ready = 1'b0;
    cfg_refract = 8'd0;
    set_cfg(4'd6, 12'h400); tick();
    for (int i = 0; i < 10; i++) begin
      word(4'd6, 16'h0100 + 16'(i), 12'h500);
      tick();
    end
    ticks(3);
    chk("ovf_level", {28'd0, evt_level}, 32'd8);
    chk("ovf_drop",  {24'd0, drop_cnt},  32'(m_drop));
    chk("ovf_drop2", {24'd0, drop_cnt},  32'd2);
    evt_ready = 1'b1;
    ticks(12);
    chk("drain_level", {28'd0, evt_level}, 32'd0);
    chk("drain_all",   32'(q.size()), 32'd0);

    // Full FIFO with push and pop on the same edge.
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      word(4'd6, 16'h0200 + 16'(i), 12'h500);
      tick();
    end
    ticks(3);
    chk("full_level", {28'd0, evt_level}, 32'd8);
    m_pop_at_push = 1'b1;
    word(4'd6, 16'h0300, 12'h500);
    tick();
    m_pop_at_push = 1'b0;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    ticks(3);
    chk("pushpop_level", {28'd0, evt_level}, 32'd8);
    chk("pushpop_drop",  {24'd0, drop_cnt},  32'd2);
    evt_ready = 1'b1;
    ticks(12);
    chk("drain2_level", {28'd0, evt_level}, 32'd0);
    chk("drain2_all",   32'(q.size()), 32'd0);

    // Reset mid-operation with events queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word(4'd6, 16'h0400 + 16'(i), 12'h500);
      tick();
    end
    ticks(3);
    chk("pre_rst_level", {28'd0, evt_level}, 32'd4);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("async_rst_level", {28'd0, evt_level}, 32'd0);
    chk("async_rst_drop",  {24'd0, drop_cnt},  32'd0);
    model_reset();
    ticks(2);
    sys_rst_n = 1'b1;
    tick();
    evt_ready = 1'b1;
    word(4'd3, 16'h0500, 12'h900); ticks(3);
    chk("post_rst_thr_900", {28'd0, evt_level}, 32'd0);
    word(4'd3, 16'h0501, 12'hFFE); tick(); tick();
    chk("post_rst_thr_ffe", {31'd0, evt_valid}, 32'd0);
    set_cfg(4'd3, 12'hFFF); tick();
    word(4'd3, 16'h0502, 12'hFFF); tick(); tick();
    chk("post_rst_thr_fff", {31'd0, evt_valid}, 32'd1);
    ticks(3);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
